// File: rtl/xor_unit_arbiter_if.sv
// rtl/xor_unit_arbiter_if.sv - requester/result bundle for the shared XOR/XNOR unit
// Optional parity output present when XOR_UNIT_ARBITER_PARITY_EN is defined.
interface xor_unit_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic             sel0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic             sel1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] result;
`ifdef XOR_UNIT_ARBITER_PARITY_EN
  logic             parity;

  modport master (
    output req0, sel0, a0, b0, req1, sel1, a1, b1,
    input  gnt0, gnt1, busy, done, done_id, result, parity
  );
  modport slave (
    input  req0, sel0, a0, b0, req1, sel1, a1, b1,
    output gnt0, gnt1, busy, done, done_id, result, parity
  );
`else
  modport master (
    output req0, sel0, a0, b0, req1, sel1, a1, b1,
    input  gnt0, gnt1, busy, done, done_id, result
  );
  modport slave (
    input  req0, sel0, a0, b0, req1, sel1, a1, b1,
    output gnt0, gnt1, busy, done, done_id, result
  );
`endif
endinterface

// File: rtl/xor_unit_arbiter.sv
// rtl/xor_unit_arbiter.sv - round-robin arbiter sharing one bit-serial XOR/XNOR unit
// Optional result parity output enabled by XOR_UNIT_ARBITER_PARITY_EN.
module xor_unit_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  xor_unit_arbiter_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_sel_q, op_sel_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic             last_id_q, last_id_d;
  logic             any_req;
  logic             win1;
  logic             do_grant;

  assign any_req = bus.req0 | bus.req1;
  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign win1    = bus.req1 & (~bus.req0 | ~last_id_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_sel_d  = op_sel_q;
    sr_d      = sr_q;
    result_d  = result_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    last_id_d = last_id_q;
    do_grant  = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) do_grant = 1'b1;
      end
      RUN: begin
        sr_d[cnt_q] = op_a_q[cnt_q] ^ op_b_q[cnt_q] ^ op_sel_q;
        if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          cnt_d     = '0;
          result_d  = sr_d;
          done_d    = 1'b1;
          done_id_d = last_id_q;
          busy_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        // Pending requests are granted straight from DONE to avoid an idle bubble.
        if (any_req) do_grant = 1'b1;
        else         state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (do_grant) begin
      state_d   = RUN;
      cnt_d     = '0;
      sr_d      = '0;
      op_a_d    = win1 ? bus.a1 : bus.a0;
      op_b_d    = win1 ? bus.b1 : bus.b0;
      op_sel_d  = win1 ? bus.sel1 : bus.sel0;
      gnt0_d    = ~win1;
      gnt1_d    = win1;
      busy_d    = 1'b1;
      last_id_d = win1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_sel_q  <= 1'b0;
      sr_q      <= '0;
      result_q  <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      last_id_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_sel_q  <= op_sel_d;
      sr_q      <= sr_d;
      result_q  <= result_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      last_id_q <= last_id_d;
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.result  = result_q;

`ifdef XOR_UNIT_ARBITER_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (done_d) parity_d = ^result_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= parity_d;
  end

  assign bus.parity = parity_q;
`endif
endmodule

// File: tb/tb_xor_unit_arbiter.sv
// tb/tb_xor_unit_arbiter.sv - scoreboard bench for xor_unit_arbiter
// Parity is also checked when XOR_UNIT_ARBITER_PARITY_EN is defined.
module tb_xor_unit_arbiter;
  localparam int WIDTH = 8;

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] res;
    int               gcyc;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  ent_t sb[$];
  logic gnt_seq[$];
  int   gnt_cyc_q[$];
  int   done_cyc_q[$];
  logic [WIDTH-1:0] res_prev = '0;

  xor_unit_arbiter_if #(.WIDTH(WIDTH)) bus ();

  xor_unit_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic sel);
    return sel ? ~(a ^ b) : (a ^ b);
  endfunction

  always @(negedge clk) begin
    ent_t e;
    cyc++;
    if (bus.gnt0 || bus.gnt1) begin
      check("gnt_exclusive", 32'(bus.gnt0 & bus.gnt1), 32'd0);
      e.id   = bus.gnt1;
      e.res  = bus.gnt1 ? model(bus.a1, bus.b1, bus.sel1) : model(bus.a0, bus.b0, bus.sel0);
      e.gcyc = cyc;
      sb.push_back(e);
      gnt_seq.push_back(bus.gnt1);
      gnt_cyc_q.push_back(cyc);
    end
    if (bus.done) begin
      done_cyc_q.push_back(cyc);
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", 32'(bus.result), 32'(e.res));
        check("done_id", 32'(bus.done_id), 32'(e.id));
        check("latency", 32'(cyc - e.gcyc), 32'(WIDTH));
`ifdef XOR_UNIT_ARBITER_PARITY_EN
        check("parity", 32'(bus.parity), 32'(^e.res));
`endif
      end
    end else if (rst_n && bus.result !== res_prev) begin
      check("result_hold", 32'(bus.result), 32'(res_prev));
    end
    res_prev = bus.result;
  end

  task automatic issue(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic sel);
    bit seen = 1'b0;
    if (id) begin
      bus.a1 = a; bus.b1 = b; bus.sel1 = sel; bus.req1 = 1'b1;
    end else begin
      bus.a0 = a; bus.b0 = b; bus.sel0 = sel; bus.req0 = 1'b1;
    end
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (id ? bus.gnt1 : bus.gnt0) seen = 1'b1;
    end
    #1;
    if (!seen) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic drop(input logic id);
    if (id) bus.req1 = 1'b0;
    else    bus.req0 = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !bus.busy && !bus.done) ok = 1'b1;
    end
    check("idle_reached", 32'(ok), 32'd1);
  endtask

  task automatic clear_logs();
    gnt_seq.delete();
    gnt_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  initial begin
    int ndone;
    bus.req0 = 1'b0; bus.sel0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
    bus.req1 = 1'b0; bus.sel1 = 1'b0; bus.a1 = '0; bus.b1 = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt0", 32'(bus.gnt0), 32'd0);
    check("rst_gnt1", 32'(bus.gnt1), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_done_id", 32'(bus.done_id), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
`ifdef XOR_UNIT_ARBITER_PARITY_EN
    check("rst_parity", 32'(bus.parity), 32'd0);
`endif

    // Tie straight out of reset: 0 first, then 1 granted on the DONE-exit edge.
    rst_n = 1'b1;
    fork
      begin issue(1'b0, 8'h3C, 8'h0F, 1'b0); drop(1'b0); end
      begin issue(1'b1, 8'hA5, 8'h5A, 1'b1); drop(1'b1); end
    join
    wait_idle();
    check("tie_ngnt", 32'(gnt_seq.size()), 32'd2);
    check("tie_ndone", 32'(done_cyc_q.size()), 32'd2);
    if (gnt_seq.size() == 2 && done_cyc_q.size() == 2 && gnt_cyc_q.size() == 2) begin
      check("tie_first", 32'(gnt_seq[0]), 32'd0);
      check("tie_second", 32'(gnt_seq[1]), 32'd1);
      check("tie_done_gap", 32'(done_cyc_q[1] - done_cyc_q[0]), 32'd9);
      check("tie_no_bubble", 32'(gnt_cyc_q[1] - done_cyc_q[0]), 32'd1);
    end
    clear_logs();

    issue(1'b0, 8'b00000101, 8'b00000110, 1'b0);
    drop(1'b0);
    wait_idle();
    check("xor_result", 32'(bus.result), 32'h03);

    issue(1'b1, 8'b00000101, 8'b00000110, 1'b1);
    drop(1'b1);
    wait_idle();
    check("xnor_result", 32'(bus.result), 32'hFC);
    clear_logs();

    // Fairness: both requesters stay high across four ops.
    fork
      begin issue(1'b0, 8'h11, 8'h22, 1'b0); issue(1'b0, 8'h33, 8'h44, 1'b1); drop(1'b0); end
      begin issue(1'b1, 8'h55, 8'h66, 1'b0); issue(1'b1, 8'h77, 8'h88, 1'b1); drop(1'b1); end
    join
    wait_idle();
    check("fair_ngnt", 32'(gnt_seq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gnt_seq.size(); i++)
      check("fair_order", 32'(gnt_seq[i]), 32'(i % 2));
    clear_logs();

    // Operand change after grant must not reach the in-flight op.
    issue(1'b0, 8'b00000101, 8'b00000110, 1'b0);
    drop(1'b0);
    repeat (2) @(negedge clk);
    #1;
    bus.a0 = 8'hFF;
    check("iso_busy", 32'(bus.busy), 32'd1);
    wait_idle();
    check("iso_result", 32'(bus.result), 32'h03);

    // Reset with cnt == 3.
    issue(1'b0, 8'h0F, 8'hF0, 1'b0);
    drop(1'b0);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd0);
    check("mid_rst_result", 32'(bus.result), 32'd0);
    check("mid_rst_done_id", 32'(bus.done_id), 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    ndone = done_cyc_q.size();
    repeat (30) @(negedge clk);
    #1;
    check("no_done_after_rst", 32'(done_cyc_q.size() - ndone), 32'd0);

    issue(1'b1, 8'h81, 8'h18, 1'b1);
    drop(1'b1);
    wait_idle();
    check("post_rst_result", 32'(bus.result), 32'h66);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
